tape_line_conditioner: RTL

//  Conditions the raw cassette line-input pin (UART_RX, "Tape Input = Line") before it reaches
//  the console tape input svi_tap_i, i.e. directly upstream of the svi_audio_in select.

---
 rtl/tape_line_conditioner.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/tape_line_conditioner.sv
// tape_line_conditioner
//   Cleans up the raw cassette line input before it feeds the console tape
//   input. The pin is optionally inverted and synchronised. A counting glitch
//   filter then produces a clean level (tape_o) and a one-clock strobe on each
//   level change (edge_o). From that strobe the block derives a carrier-present
//   flag (active_o) and a saturating edge counter (edge_cnt_o).
// Ports
//   clk_i       system clock
//   reset_n_i   asynchronous active-low reset
//   clk_en_i    sample enable; the filter counter and activity timer advance only when it is high
//   tape_raw_i  raw line input, asynchronous to clk_i
//   invert_i    1 = invert line polarity ahead of the synchroniser
//   clr_i       synchronous clear of edge_cnt_o
//   tape_o      filtered tape level (registered)
//   edge_o      one-clock pulse on every tape_o transition
//   active_o    signal present
//   edge_cnt_o  filtered edges since reset/clear, saturating at 16'hFFFF
module tape_line_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 16,
  parameter int MIN_EDGES   = 8,
  parameter int ACT_TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        clk_en_i,
  input  logic        tape_raw_i,
  input  logic        invert_i,
  input  logic        clr_i,
  output logic        tape_o,
  output logic        edge_o,
  output logic        active_o,
  output logic [15:0] edge_cnt_o
);

  localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int ACW = $clog2(MIN_EDGES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILT_LEN - 1);
  localparam logic [ACW-1:0] ARM_LAST  = ACW'(MIN_EDGES - 1);
  localparam logic [19:0]    TMO       = 20'(ACT_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ARM, ACTIVE} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sy;
  logic [FCW-1:0]         fcnt;
  logic [19:0]            timer;
  logic [ACW-1:0]         arm_cnt;
  state_t                 state;

  // Synchroniser runs on every clock; only the filter is sample-gated.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_q <= '0;
    else            sync_q <= {sync_q[SYNC_STAGES-2:0], tape_raw_i ^ invert_i};
  end

  assign sy = sync_q[SYNC_STAGES-1];

  // Glitch filter: tape_o flips only after FILT_LEN consecutive differing
  // samples; any agreeing sample restarts the run.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fcnt   <= '0;
      tape_o <= 1'b0;
      edge_o <= 1'b0;
    end else begin
      edge_o <= 1'b0;
      if (clk_en_i) begin
        if (sy == tape_o) begin
          fcnt <= '0;
        end else if (fcnt == FILT_LAST) begin
          tape_o <= sy;
          fcnt   <= '0;
          edge_o <= 1'b1;
        end else begin
          fcnt <= fcnt + FCW'(1);
        end
      end
    end
  end

  // Enabled samples since the last edge; an edge clears it even when a
  // sample lands in the same cycle.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                    timer <= '0;
    else if (edge_o)                   timer <= '0;
    else if (clk_en_i && timer != TMO) timer <= timer + 20'd1;
  end

  // Activity FSM. An edge takes precedence over a stale timeout because the
  // timer is being cleared by that same edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= IDLE;
      arm_cnt  <= '0;
      active_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (edge_o) begin
            if (MIN_EDGES == 1) begin
              state    <= ACTIVE;
              active_o <= 1'b1;
            end else begin
              state   <= ARM;
              arm_cnt <= ACW'(1);
            end
          end
        end
        ARM: begin
          if (edge_o) begin
            if (arm_cnt == ARM_LAST) begin
              state    <= ACTIVE;
              active_o <= 1'b1;
              arm_cnt  <= '0;
            end else begin
              arm_cnt <= arm_cnt + ACW'(1);
            end
          end else if (timer == TMO) begin
            state   <= IDLE;
            arm_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (!edge_o && timer == TMO) begin
            state    <= IDLE;
            active_o <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          arm_cnt  <= '0;
          active_o <= 1'b0;
        end
      endcase
    end
  end

  // Saturating edge counter; clear beats a coincident edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                             edge_cnt_o <= '0;
    else if (clr_i)                             edge_cnt_o <= '0;
    else if (edge_o && edge_cnt_o != 16'hFFFF)  edge_cnt_o <= edge_cnt_o + 16'd1;
  end

endmodule
